// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and default width for the serial subtractor
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fs_cell.sv
// rtl/fs_cell.sv - one-bit full subtractor: d = x - y - bin, bout is the borrow out
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - b_in, LSB first, one bit per clock
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             b_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res;
  logic             br;
  logic             d;
  logic             bout;
  logic             load;
  logic             step;
  logic             last;

  assign last = (cnt == LAST_BIT);

  fs_cell u_cell (
    .x    (a_reg[0]),
    .y    (b_reg[0]),
    .bin  (br),
    .d    (d),
    .bout (bout)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        // start here chains the next operation with no idle gap
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      res        <= '0;
      br         <= 1'b0;
      difference <= '0;
      b_out      <= 1'b0;
    end else if (load) begin
      cnt   <= '0;
      a_reg <= a;
      b_reg <= b;
      br    <= b_in;
      res   <= '0;
    end else if (step) begin
      cnt   <= cnt + 1'b1;
      a_reg <= a_reg >> 1;
      b_reg <= b_reg >> 1;
      br    <= bout;
      res   <= {d, res[WIDTH-1:1]};
      // the final bit is folded in directly so the outputs update on the DONE-entry edge
      if (last) begin
        difference <= {d, res[WIDTH-1:1]};
        b_out      <= bout;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       b_in;
  logic       busy;
  logic       done;
  logic [7:0] difference;
  logic       b_out;

  int checks;
  int failures;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .b_out      (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // counts rising edges until done is seen at a falling edge; n=99 means timeout
  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) return;
    end
    n = 99;
  endtask

  task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    a = av; b = bv; b_in = bi; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic bi, input logic [7:0] ed, input logic eb);
    int n;
    @(negedge clk);
    issue(av, bv, bi);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(n);
    check({tag, "_lat"}, 32'(n + 1), 32'd9);
    check({tag, "_diff"}, 32'(difference), 32'(ed));
    check({tag, "_bout"}, 32'(b_out), 32'(eb));
    @(negedge clk);
    check({tag, "_done_clr"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    checks = 0;
    failures = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(difference), 32'd0);
    check("rst_bout", 32'(b_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("v05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    run_op("v03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
    run_op("v00_00_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    run_op("vFF_00", 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);
    run_op("vFF_FF_b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run_op("v80_7F", 8'h80, 8'h7F, 1'b0, 8'h01, 1'b0);

    // start and new operands mid-RUN must be ignored
    @(negedge clk);
    issue(8'h10, 8'h01, 1'b0);
    @(negedge clk);
    a = 8'h00; b = 8'h01; b_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("ign_lat", 32'(n + 3), 32'd9);
    check("ign_diff", 32'(difference), 32'h0F);
    check("ign_bout", 32'(b_out), 32'd0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("ign_one_done", 32'(pulses), 32'd0);

    // back-to-back: second start issued during the DONE cycle
    @(negedge clk);
    issue(8'h20, 8'h10, 1'b0);
    wait_done(n);
    check("b2b1_diff", 32'(difference), 32'h10);
    check("b2b1_bout", 32'(b_out), 32'd0);
    a = 8'h01; b = 8'h02; b_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_nodone", 32'(done), 32'd0);
    wait_done(n);
    check("b2b_gap", 32'(n + 1), 32'd9);
    check("b2b2_diff", 32'(difference), 32'hFF);
    check("b2b2_bout", 32'(b_out), 32'd1);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    issue(8'h05, 8'h03, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_diff", 32'(difference), 32'd0);
    check("arst_bout", 32'(b_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("arst_no_done", 32'(pulses), 32'd0);
    run_op("post_rst", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
